load_store_unit: RTL and testbench

- Initiator-side controller between the processor datapath and the word-wide data memory.
- Accepts byte, halfword and word loads and stores over a valid/ready request channel.
- Drives the memory's `mem_write`/address/write-data bus. Memory read data is valid one cycle after the address is presented.
- Implements sub-word stores as read-modify-write, sign- or zero-extends sub-word loads, and rejects misaligned or out-of-range accesses without touching memory.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/byte_lane_unit.sv | 48 ++++
 rtl/load_store_unit.sv | 124 ++++++++++++
 tb/tb_load_store_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: access sizes, FSM states,
// the default data-memory limit and the request legality check.
package lsu_pkg;

  localparam logic [31:0] DEFAULT_ADDR_LIMIT = 32'h0000_1000;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    DONE    = 3'd4
  } lsu_state_t;

  // Illegal size, misalignment for the size, or an address past the memory.
  function automatic logic access_error(input logic [1:0] size, input logic [31:0] addr,
                                        input logic [31:0] limit);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr[0];
      SIZE_WORD: bad = (addr[1:0] != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad | (addr >= limit);
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Little-endian lane handling: extracts and extends sub-word load data and
// merges sub-word store data into a previously read word.
module byte_lane_unit
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  size_t       size,
  input  logic        is_signed,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [31:0] shifted;

  // Lane extraction/extension and store merge.
  always_comb begin
    shifted   = word >> {lane, 3'b000};
    load_data = shifted;
    merged    = word;
    case (size)
      SIZE_BYTE: begin
        load_data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
        case (lane)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          2'd3:    merged[31:24] = wdata[7:0];
          default: merged        = word;
        endcase
      end
      SIZE_HALF: begin
        load_data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
        if (lane[1]) begin
          merged[31:16] = wdata;
        end else begin
          merged[15:0] = wdata;
        end
      end
      default: begin
        load_data = word;
        merged    = word;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, performs word accesses directly
// and sub-word stores as read-modify-write, and rejects illegal requests early.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [31:0] ADDR_LIMIT = DEFAULT_ADDR_LIMIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] resp_rdata,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  lsu_state_t  state, state_next;
  logic [31:0] addr_r;
  logic [1:0]  size_r;
  logic        signed_r;
  logic        write_r;
  logic [31:0] data_r;
  logic [31:0] rdata_r;
  logic        err_r;
  logic        req_err;
  logic [31:0] lane_load;
  logic [31:0] lane_merged;

  assign req_err = access_error(req_size, req_addr, ADDR_LIMIT);

  byte_lane_unit u_lanes (
    .word      (mem_read_data),
    .lane      (addr_r[1:0]),
    .size      (size_t'(size_r)),
    .is_signed (signed_r),
    .wdata     (data_r[15:0]),
    .load_data (lane_load),
    .merged    (lane_merged)
  );

  // Next-state selection.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err) begin
            state_next = DONE;
          end else if (req_write && (req_size == SIZE_WORD)) begin
            state_next = WR;
          end else begin
            state_next = RD;
          end
        end else begin
          state_next = IDLE;
        end
      end
      RD:      state_next = RD_WAIT;
      RD_WAIT: state_next = write_r ? WR : DONE;
      WR:      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, request capture and load/merge data registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr_r   <= 32'd0;
      size_r   <= 2'b00;
      signed_r <= 1'b0;
      write_r  <= 1'b0;
      data_r   <= 32'd0;
      rdata_r  <= 32'd0;
      err_r    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_r   <= req_addr;
            size_r   <= req_size;
            signed_r <= req_signed;
            write_r  <= req_write;
            data_r   <= req_wdata;
            err_r    <= req_err;
            if (req_err) begin
              rdata_r <= 32'd0;
            end
          end
        end
        RD_WAIT: begin
          if (write_r) begin
            data_r <= lane_merged;
          end else begin
            rdata_r <= lane_load;
          end
        end
        // Stores report zero data in their DONE cycle.
        WR: rdata_r <= 32'd0;
        default: ;
      endcase
    end
  end

  assign req_ready      = (state == IDLE);
  assign resp_valid     = (state == DONE);
  assign resp_error     = (state == DONE) && err_r;
  assign resp_rdata     = rdata_r;
  assign mem_write      = (state == WR) && !reset;
  assign mem_address    = {addr_r[31:2], 2'b00};
  assign mem_write_data = data_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a one-cycle-latency word memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic        mem_write;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  logic [31:0] mem [0:1023];
  int          write_count = 0;
  logic [31:0] last_waddr = 32'd0;
  logic [31:0] last_wdata = 32'd0;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_error(resp_error), .resp_rdata(resp_rdata),
    .mem_write(mem_write), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_address[11:2]] <= mem_write_data;
      write_count <= write_count + 1;
      last_waddr  <= mem_address;
      last_wdata  <= mem_write_data;
    end
    mem_read_data <= mem[mem_address[11:2]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
  endtask

  // One request: checks latency, error flag, load data and number of memory writes.
  task automatic run_req(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                         input logic exp_err, input logic [31:0] exp_rd, input int exp_writes);
    int lat;
    int w0;
    bit seen;
    w0 = write_count;
    @(negedge clk);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    drive(w, sz, sg, a, wd);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 10) begin
      @(negedge clk);
      lat++;
      if (resp_valid) seen = 1'b1;
    end
    check({tag, "_latency"}, lat, seen ? exp_lat : -1);
    check({tag, "_error"}, {31'd0, resp_error}, {31'd0, exp_err});
    check({tag, "_rdata"}, resp_rdata, exp_rd);
    check({tag, "_writes"}, write_count - w0, exp_writes);
  endtask

  initial begin
    int nresp;
    logic [5:0] exp_ready;
    logic [5:0] exp_valid;
    reset = 1'b1;
    req_valid = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_error", {31'd0, resp_error}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_mem_address", mem_address, 32'd0);
    check("rst_mem_wdata", mem_write_data, 32'd0);
    reset = 1'b0;

    // Word store then load.
    run_req("sw8", 1'b1, 2'b10, 1'b0, 32'h008, 32'hCAFEBABE, 2, 1'b0, 32'd0, 1);
    check("sw8_waddr", last_waddr, 32'h008);
    check("sw8_wdata", last_wdata, 32'hCAFEBABE);
    run_req("lw8", 1'b0, 2'b10, 1'b0, 32'h008, 32'd0, 3, 1'b0, 32'hCAFEBABE, 0);

    // Sub-word loads from 0x80FF7F01.
    run_req("sw0", 1'b1, 2'b10, 1'b0, 32'h000, 32'h80FF7F01, 2, 1'b0, 32'd0, 1);
    run_req("lb2s", 1'b0, 2'b00, 1'b1, 32'h002, 32'd0, 3, 1'b0, 32'hFFFFFFFF, 0);
    run_req("lb3u", 1'b0, 2'b00, 1'b0, 32'h003, 32'd0, 3, 1'b0, 32'h00000080, 0);
    run_req("lh2s", 1'b0, 2'b01, 1'b1, 32'h002, 32'd0, 3, 1'b0, 32'hFFFF80FF, 0);
    run_req("lh0u", 1'b0, 2'b01, 1'b0, 32'h000, 32'd0, 3, 1'b0, 32'h00007F01, 0);
    run_req("lb1s", 1'b0, 2'b00, 1'b1, 32'h001, 32'd0, 3, 1'b0, 32'h0000007F, 0);

    // Read-modify-write stores.
    run_req("sw4", 1'b1, 2'b10, 1'b0, 32'h004, 32'h11223344, 2, 1'b0, 32'd0, 1);
    run_req("sb5", 1'b1, 2'b00, 1'b0, 32'h005, 32'hFFFFFFAB, 4, 1'b0, 32'd0, 1);
    check("sb5_waddr", last_waddr, 32'h004);
    check("sb5_wdata", last_wdata, 32'h1122AB44);
    run_req("sh6", 1'b1, 2'b01, 1'b0, 32'h006, 32'h0000BEEF, 4, 1'b0, 32'd0, 1);
    run_req("lw4", 1'b0, 2'b10, 1'b0, 32'h004, 32'd0, 3, 1'b0, 32'hBEEFAB44, 0);

    // Highest legal word, then illegal requests.
    run_req("swtop", 1'b1, 2'b10, 1'b0, 32'h0FFC, 32'h12345678, 2, 1'b0, 32'd0, 1);
    run_req("lwtop", 1'b0, 2'b10, 1'b0, 32'h0FFC, 32'd0, 3, 1'b0, 32'h12345678, 0);
    run_req("e_lw6", 1'b0, 2'b10, 1'b0, 32'h006, 32'd0, 1, 1'b1, 32'd0, 0);
    run_req("e_sh1", 1'b1, 2'b01, 1'b0, 32'h001, 32'h1234, 1, 1'b1, 32'd0, 0);
    run_req("e_sz3", 1'b1, 2'b11, 1'b0, 32'h000, 32'hDEADBEEF, 1, 1'b1, 32'd0, 0);
    run_req("e_lim", 1'b1, 2'b10, 1'b0, 32'h1000, 32'hDEADBEEF, 1, 1'b1, 32'd0, 0);
    run_req("lw0", 1'b0, 2'b10, 1'b0, 32'h000, 32'd0, 3, 1'b0, 32'h80FF7F01, 0);

    // Back-to-back: word store then word load with req_valid held high.
    exp_ready = 6'b000100;
    exp_valid = 6'b100010;
    nresp = 0;
    @(negedge clk);
    drive(1'b1, 2'b10, 1'b0, 32'h010, 32'hA5A5A5A5);
    req_valid = 1'b1;
    @(posedge clk);
    #1 drive(1'b0, 2'b10, 1'b0, 32'h010, 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("b2b_ready_c%0d", k + 1), {31'd0, req_ready}, {31'd0, exp_ready[k]});
      check($sformatf("b2b_valid_c%0d", k + 1), {31'd0, resp_valid}, {31'd0, exp_valid[k]});
      if (resp_valid) nresp++;
    end
    req_valid = 1'b0;
    check("b2b_rdata", resp_rdata, 32'hA5A5A5A5);
    check("b2b_nresp", nresp, 2);

    // Reset while a byte store sits in WR.
    run_req("sw20", 1'b1, 2'b10, 1'b0, 32'h020, 32'h55667788, 2, 1'b0, 32'd0, 1);
    nresp = write_count;
    @(negedge clk);
    drive(1'b1, 2'b00, 1'b0, 32'h020, 32'h00000099);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rstwr_in_wr", {31'd0, mem_write}, 32'd1);
    reset = 1'b1;
    #1 check("rstwr_gated", {31'd0, mem_write}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rstwr_ready", {31'd0, req_ready}, 32'd1);
    check("rstwr_valid", {31'd0, resp_valid}, 32'd0);
    check("rstwr_writes", write_count - nresp, 0);
    run_req("lw20", 1'b0, 2'b10, 1'b0, 32'h020, 32'd0, 3, 1'b0, 32'h55667788, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
